// File: rtl/vout_pkg.sv
// vout_pkg: state encoding, burst/FIFO defaults and length helper shared by the vout memory-side schedulers.
package vout_pkg;
    localparam int MAX_BURST_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 512;

    typedef enum logic [3:0] {
        IDLE, PREP, LINE_START, WAIT_SPACE, REQ, BURST_END, LINE_END, DRAIN, DONE
    } state_e;

    function automatic int unsigned min_len(input int unsigned remain, input int unsigned max_burst);
        return (remain < max_burst) ? remain : max_burst;
    endfunction
endpackage

// File: rtl/vout_frame_read_sched_if.sv
// vout_frame_read_sched_if: burst-read handshake between the frame read scheduler and the DDR arbiter.
interface vout_frame_read_sched_if #(
    parameter int ADDR_BITS = 24,
    parameter int LEN_BITS  = 10
);
    logic                 rd_burst_req;
    logic [LEN_BITS-1:0]  rd_burst_len;
    logic [ADDR_BITS-1:0] rd_burst_addr;
    logic                 rd_burst_data_valid;
    logic                 burst_finish;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data_valid, burst_finish
    );
    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data_valid, burst_finish
    );
endinterface

// File: rtl/vout_line_addr_gen.sv
// vout_line_addr_gen: frame-buffer base and per-line start address, top-down or bottom-up.
module vout_line_addr_gen #(
    parameter int ADDR_BITS = 24,
    parameter int DIM_BITS  = 12,
    parameter int BUF_BITS  = 2,
    parameter int BUF_SHIFT = 21
) (
    input  logic                 mem_clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [BUF_BITS-1:0]  buf_sel,
    input  logic [DIM_BITS-1:0]  height,
    input  logic [ADDR_BITS-1:0] stride,
    input  logic                 vflip,
    output logic [ADDR_BITS-1:0] line_addr
);
    logic [ADDR_BITS-1:0] base, last_off, line_addr_d, line_addr_q;

    assign base     = ADDR_BITS'({buf_sel, {BUF_SHIFT{1'b0}}});
    // offset of the bottom line; the product is only ever consumed through the register
    assign last_off = (ADDR_BITS'(height) - ADDR_BITS'(1)) * stride;

    always_comb begin
        line_addr_d = line_addr_q;
        if (load)
            line_addr_d = base + (vflip ? last_off : '0);
        else if (step)
            line_addr_d = vflip ? line_addr_q - stride : line_addr_q + stride;
    end

    always_ff @(posedge mem_clk or posedge rst)
        if (rst) line_addr_q <= '0;
        else     line_addr_q <= line_addr_d;

    assign line_addr = line_addr_q;
endmodule

// File: rtl/vout_frame_read_sched.sv
// vout_frame_read_sched: fetches one frame from a selectable DDR frame buffer, line by line, as bursts
// into the external line FIFO, with vertical flip and safe restart on a mid-burst frame start.
module vout_frame_read_sched
    import vout_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter int LEN_BITS      = 10,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int CNT_BITS      = 12,
    parameter int DIM_BITS      = 12,
    parameter int BUF_BITS      = 2,
    parameter int BUF_SHIFT     = 21
) (
    input  logic                 mem_clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [DIM_BITS-1:0]  cfg_width,
    input  logic [DIM_BITS-1:0]  cfg_height,
    input  logic [ADDR_BITS-1:0] cfg_stride,
    input  logic [BUF_BITS-1:0]  cfg_buf_sel,
    input  logic                 cfg_vflip,
    input  logic [CNT_BITS-1:0]  fifo_wrusedw,
    output logic                 fifo_aclr,
    vout_frame_read_sched_if.master rd,
    output logic                 busy,
    output logic                 frame_done,
    output logic [DIM_BITS-1:0]  line_cnt
);
    localparam logic [CNT_BITS-1:0] SPACE_THR = CNT_BITS'(FIFO_DEPTH - MAX_BURST);

    if (MAX_BURST > (2 ** LEN_BITS) - 1 || MEM_DATA_BITS % 8 != 0) begin : g_bad_cfg
        $error("vout_frame_read_sched: MAX_BURST exceeds rd_burst_len range or bad beat width");
    end

    state_e               state_d, state_q;
    logic [DIM_BITS-1:0]  width_d, width_q, height_d, height_q, remain_d, remain_q;
    logic [DIM_BITS-1:0]  line_cnt_d, line_cnt_q;
    logic [ADDR_BITS-1:0] stride_d, stride_q, addr_d, addr_q, line_addr;
    logic [BUF_BITS-1:0]  buf_sel_d, buf_sel_q;
    logic [LEN_BITS-1:0]  len_d, len_q;
    logic                 vflip_d, vflip_q, req_d, req_q, aclr_d, aclr_q, load, step;

    vout_line_addr_gen #(
        .ADDR_BITS(ADDR_BITS), .DIM_BITS(DIM_BITS), .BUF_BITS(BUF_BITS), .BUF_SHIFT(BUF_SHIFT)
    ) u_addr (
        .mem_clk(mem_clk), .rst(rst), .load(load), .step(step),
        .buf_sel(buf_sel_q), .height(height_q), .stride(stride_q), .vflip(vflip_q),
        .line_addr(line_addr)
    );

    always_comb begin
        width_d   = frame_start ? cfg_width   : width_q;
        height_d  = frame_start ? cfg_height  : height_q;
        stride_d  = frame_start ? cfg_stride  : stride_q;
        buf_sel_d = frame_start ? cfg_buf_sel : buf_sel_q;
        vflip_d   = frame_start ? cfg_vflip   : vflip_q;
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        len_d      = len_q;
        req_d      = 1'b0;
        line_cnt_d = line_cnt_q;
        aclr_d     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: if (frame_start) state_d = PREP;
            PREP: begin
                load       = 1'b1;
                line_cnt_d = '0;
                state_d    = (width_q == '0 || height_q == '0) ? DONE : LINE_START;
            end
            LINE_START: begin
                remain_d = width_q;
                addr_d   = line_addr;
                state_d  = WAIT_SPACE;
            end
            WAIT_SPACE: if (fifo_wrusedw <= SPACE_THR) begin
                state_d = REQ;
                req_d   = 1'b1;
                len_d   = LEN_BITS'(min_len(32'(remain_q), MAX_BURST));
            end
            REQ: begin
                req_d = req_q && !(rd.rd_burst_data_valid || rd.burst_finish);
                if (rd.burst_finish) begin
                    addr_d   = addr_q + ADDR_BITS'(len_q);
                    remain_d = remain_q - DIM_BITS'(len_q);
                    state_d  = BURST_END;
                end
            end
            BURST_END: state_d = (remain_q == '0) ? LINE_END : WAIT_SPACE;
            LINE_END: begin
                line_cnt_d = line_cnt_q + DIM_BITS'(1);
                step       = 1'b1;
                state_d    = (line_cnt_d == height_q) ? DONE : LINE_START;
            end
            DRAIN: begin
                req_d  = req_q && !(rd.rd_burst_data_valid || rd.burst_finish);
                aclr_d = !rd.burst_finish;
                if (rd.burst_finish) state_d = PREP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a restart wins over everything; an outstanding burst must still be drained before refetching
        if (frame_start) begin
            state_d  = (state_q == REQ || state_q == DRAIN) ? DRAIN : PREP;
            req_d    = (state_d == DRAIN) ? req_d : 1'b0;
            addr_d   = addr_q;
            remain_d = remain_q;
            len_d    = len_q;
            step     = 1'b0;
            aclr_d   = 1'b1;
        end
    end

    always_ff @(posedge mem_clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            buf_sel_q  <= '0;
            vflip_q    <= 1'b0;
            remain_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            req_q      <= 1'b0;
            line_cnt_q <= '0;
            aclr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            stride_q   <= stride_d;
            buf_sel_q  <= buf_sel_d;
            vflip_q    <= vflip_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            req_q      <= req_d;
            line_cnt_q <= line_cnt_d;
            aclr_q     <= aclr_d;
        end

    assign rd.rd_burst_req  = req_q;
    assign rd.rd_burst_len  = len_q;
    assign rd.rd_burst_addr = addr_q;
    assign fifo_aclr        = aclr_q;
    assign busy             = state_q != IDLE;
    assign frame_done       = state_q == DONE;
    assign line_cnt         = line_cnt_q;
endmodule

// File: tb/tb_vout_frame_read_sched.sv
// tb_vout_frame_read_sched: directed frames against hand-computed burst addresses, lengths and timing.
module tb_vout_frame_read_sched;
    logic        mem_clk = 1'b0, rst = 1'b1, frame_start = 1'b0, cfg_vflip = 1'b0;
    logic        fifo_aclr, busy, frame_done;
    logic [11:0] cfg_width = '0, cfg_height = '0, fifo_wrusedw = '0, line_cnt;
    logic [23:0] cfg_stride = '0;
    logic [1:0]  cfg_buf_sel = '0;
    logic        req_prev = 1'b0;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0, req_cnt = 0;

    vout_frame_read_sched_if #(.ADDR_BITS(24), .LEN_BITS(10)) rd();

    vout_frame_read_sched dut (
        .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .cfg_buf_sel(cfg_buf_sel), .cfg_vflip(cfg_vflip), .fifo_wrusedw(fifo_wrusedw),
        .fifo_aclr(fifo_aclr), .rd(rd), .busy(busy), .frame_done(frame_done), .line_cnt(line_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    always @(negedge mem_clk) begin
        if (frame_done) done_cnt++;
        if (rd.rd_burst_req && !req_prev) req_cnt++;
        req_prev = rd.rd_burst_req;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic start(input int w, input int h, input logic [23:0] s, input int b, input bit vf);
        @(negedge mem_clk);
        cfg_width   = 12'(w);
        cfg_height  = 12'(h);
        cfg_stride  = s;
        cfg_buf_sel = 2'(b);
        cfg_vflip   = vf;
        frame_start = 1'b1;
        @(negedge mem_clk);
        frame_start = 1'b0;
    endtask

    // waits for a request, checks it, then acts as the arbiter: one beat, then burst_finish
    task automatic serve(input string tag, input logic [23:0] ea, input int el, input int ew);
        int w = 0;
        do begin @(negedge mem_clk); w++; end while (!rd.rd_burst_req && w < 60);
        chk({tag, "_req"}, 32'(rd.rd_burst_req), 1);
        chk({tag, "_lat"}, w, ew);
        chk({tag, "_addr"}, 32'(rd.rd_burst_addr), 32'(ea));
        chk({tag, "_len"}, 32'(rd.rd_burst_len), el);
        rd.rd_burst_data_valid = 1'b1;
        @(negedge mem_clk);
        rd.rd_burst_data_valid = 1'b0;
        chk({tag, "_drop"}, 32'(rd.rd_burst_req), 0);
        rd.burst_finish = 1'b1;
        @(negedge mem_clk);
        rd.burst_finish = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        do begin @(negedge mem_clk); w++; end while (busy && w < 100);
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int d0, r0, hi, w;
        rd.rd_burst_data_valid = 1'b0;
        rd.burst_finish        = 1'b0;
        repeat (3) @(negedge mem_clk);
        chk("rst_req", 32'(rd.rd_burst_req), 0);
        chk("rst_addr", 32'(rd.rd_burst_addr), 0);
        chk("rst_len", 32'(rd.rd_burst_len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_aclr", 32'(fifo_aclr), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_lines", 32'(line_cnt), 0);
        rst = 1'b0;

        // two full lines from buffer 1
        start(64, 2, 24'd2048, 1, 1'b0);
        serve("t1b0", 24'h200000, 32, 3);
        serve("t1b1", 24'h200020, 32, 2);
        serve("t1b2", 24'h200800, 32, 4);
        serve("t1b3", 24'h200820, 32, 2);
        wait_idle("t1_idle");
        chk("t1_done", done_cnt, 1);
        chk("t1_lines", 32'(line_cnt), 2);
        chk("t1_reqs", req_cnt, 4);

        // remainder burst
        r0 = req_cnt;
        start(70, 1, 24'd4096, 0, 1'b0);
        serve("t2b0", 24'd0, 32, 3);
        serve("t2b1", 24'd32, 32, 2);
        serve("t2b2", 24'd64, 6, 2);
        wait_idle("t2_idle");
        chk("t2_reqs", req_cnt - r0, 3);

        // vertical flip
        start(32, 3, 24'd1024, 0, 1'b1);
        serve("t3l0", 24'd2048, 32, 3);
        serve("t3l1", 24'd1024, 32, 4);
        serve("t3l2", 24'd0, 32, 4);
        wait_idle("t3_idle");
        chk("t3_lines", 32'(line_cnt), 3);

        // FIFO space threshold
        fifo_wrusedw = 12'd481;
        start(32, 1, 24'd0, 0, 1'b0);
        hi = 0;
        repeat (10) begin @(negedge mem_clk); if (rd.rd_burst_req) hi++; end
        chk("t4_hold", hi, 0);
        fifo_wrusedw = 12'd480;
        @(negedge mem_clk);
        chk("t4_go", 32'(rd.rd_burst_req), 1);
        serve("t4b0", 24'd0, 32, 1);
        fifo_wrusedw = 12'd0;
        wait_idle("t4_idle");

        // restart while a burst is outstanding
        d0 = done_cnt;
        r0 = req_cnt;
        start(64, 2, 24'd2048, 0, 1'b0);
        w = 0;
        do begin @(negedge mem_clk); w++; end while (!rd.rd_burst_req && w < 20);
        chk("t5_req", 32'(rd.rd_burst_req), 1);
        cfg_width   = 12'd32;
        cfg_height  = 12'd1;
        cfg_buf_sel = 2'd2;
        frame_start = 1'b1;
        @(negedge mem_clk);
        frame_start = 1'b0;
        cfg_width   = 12'd0;
        cfg_buf_sel = 2'd3;
        chk("t5_req_held", 32'(rd.rd_burst_req), 1);
        hi = 0;
        for (int i = 1; i <= 5; i++) begin
            if (fifo_aclr) hi++;
            if (i == 5) rd.burst_finish = 1'b1;
            else @(negedge mem_clk);
        end
        @(negedge mem_clk);
        rd.burst_finish = 1'b0;
        chk("t5_aclr_hi", hi, 5);
        chk("t5_aclr_lo", 32'(fifo_aclr), 0);
        serve("t5b0", 24'h400000, 32, 3);
        wait_idle("t5_idle");
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_reqs", req_cnt - r0, 2);
        chk("t5_lines", 32'(line_cnt), 1);

        // empty frame
        r0 = req_cnt;
        start(32, 0, 24'd0, 0, 1'b0);
        chk("t6_done_n1", 32'(frame_done), 0);
        @(negedge mem_clk);
        chk("t6_done_n2", 32'(frame_done), 1);
        @(negedge mem_clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_reqs", req_cnt - r0, 0);

        // asynchronous reset mid-burst
        start(32, 1, 24'd0, 1, 1'b0);
        w = 0;
        do begin @(negedge mem_clk); w++; end while (!rd.rd_burst_req && w < 20);
        chk("t7_addr_pre", 32'(rd.rd_burst_addr), 32'h200000);
        rd.rd_burst_data_valid = 1'b1;
        @(negedge mem_clk);
        rd.rd_burst_data_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t7_req", 32'(rd.rd_burst_req), 0);
        chk("t7_addr", 32'(rd.rd_burst_addr), 0);
        chk("t7_len", 32'(rd.rd_burst_len), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_aclr", 32'(fifo_aclr), 0);
        @(negedge mem_clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
